// File: rtl/os_array_pkg.sv
// Shared definitions for the output-stationary MAC array: default geometry
// and the operand feeder state encoding.
package os_array_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ROWS  = 4;
    localparam int DEF_COLS  = 4;
    localparam int DEF_KW    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

endpackage

// File: rtl/skew_line.sv
// DEPTH-stage shift register used to stagger one operand lane so that
// lane k arrives at the array edge k cycles after lane 0.
module skew_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage[s] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int s = 1; s < DEPTH; s++) begin
                stage[s] <= stage[s-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/os_array_feeder.sv
// Operand feeder for the output-stationary systolic array: accepts A-column /
// B-row beats, skews them onto the west/north edges, owns clc and done.
module os_array_feeder
    import os_array_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int KW    = DEF_KW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ROWS*WIDTH-1:0] in_a,
    input  logic [COLS*WIDTH-1:0] in_b,
    output logic [ROWS*WIDTH-1:0] a_edge,
    output logic [COLS*WIDTH-1:0] b_edge,
    output logic                 clc,
    output logic                 busy,
    output logic                 done
);

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on state, never on in_valid.

    localparam int DRAIN_CYCLES = ROWS + COLS;
    localparam int DW           = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    state_t state;
    state_t state_next;
    logic   done_next;

    logic [KW-1:0] k_len_q;
    logic [KW-1:0] beat_cnt;
    logic [DW-1:0] drain_cnt;
    logic          accept;
    logic          last_beat;

    logic [ROWS*WIDTH-1:0] a_hold;
    logic [COLS*WIDTH-1:0] b_hold;

    assign accept    = (state == STREAM) && in_valid;
    assign last_beat = accept && ((beat_cnt + KW'(1)) == k_len_q);

    assign in_ready = (state == STREAM);
    assign clc      = (state == CLEAR);
    assign busy     = (state != IDLE);

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = CLEAR;
            end
            CLEAR: begin
                // A zero-length tile skips streaming but still waits out the drain.
                state_next = (k_len_q == '0) ? DRAIN : STREAM;
            end
            STREAM: begin
                if (last_beat) state_next = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            done      <= 1'b0;
            k_len_q   <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_next;
            done  <= done_next;
            if (state == IDLE && start) begin
                k_len_q <= k_len;
            end
            if (state == CLEAR) begin
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + KW'(1);
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
        end
    end

    // Bubble cycles load zeros so the array adds nothing while staying aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_hold <= '0;
            b_hold <= '0;
        end else begin
            a_hold <= accept ? in_a : '0;
            b_hold <= accept ? in_b : '0;
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_a_lane
        skew_line #(
            .WIDTH(WIDTH),
            .DEPTH(1 + i)
        ) u_skew (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (a_hold[i*WIDTH +: WIDTH]),
            .q    (a_edge[i*WIDTH +: WIDTH])
        );
    end

    for (genvar j = 0; j < COLS; j++) begin : g_b_lane
        skew_line #(
            .WIDTH(WIDTH),
            .DEPTH(1 + j)
        ) u_skew (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (b_hold[j*WIDTH +: WIDTH]),
            .q    (b_edge[j*WIDTH +: WIDTH])
        );
    end

endmodule
